// File: rtl/keccak_squeeze.sv
// keccak_squeeze: output side of the Keccak sponge.
// Latches a full 1600-bit permuted state, streams its rate lanes as 64-bit
// words over valid/ready, and requests another permutation whenever the
// rate is exhausted while output words are still owed (SHA3 / SHAKE).
module keccak_squeeze #(
    parameter int RATE_LANES = 17,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] out_words,
    output logic             busy,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [1599:0]    st_data,
    output logic             perm_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic             done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_ST = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    localparam logic [4:0]       LAST_IDX = 5'(RATE_LANES - 1);
    localparam logic [LEN_W-1:0] REM_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] REM_TWO  = LEN_W'(2);

    logic [1:0]       fsm;
    logic [1599:0]    lanes;
    logic [4:0]       idx;
    logic [LEN_W-1:0] rem;

    logic             out_hs;
    logic [4:0]       idx_inc;
    logic [63:0]      next_lane;

    assign busy     = (fsm != S_IDLE);
    assign st_ready = (fsm == S_WAIT_ST);
    assign out_hs   = out_valid & out_ready;
    assign idx_inc  = idx + 5'd1;

    // Next lane to present after a handshake; only used while idx_inc is inside the rate.
    assign next_lane = lanes[{idx_inc, 6'd0} +: 64];

    // Capture the permuted state on the state handshake; deliberately not reset.
    always_ff @(posedge clk) begin
        if (fsm == S_WAIT_ST && st_valid) begin
            lanes <= st_data;
        end
    end

    // Squeeze sequencer: request intake, state wait, word emission and pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= S_IDLE;
            idx       <= '0;
            rem       <= '0;
            perm_req  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            perm_req <= 1'b0;
            done     <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        if (out_words != '0) begin
                            rem <= out_words;
                            fsm <= S_WAIT_ST;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_WAIT_ST: begin
                    if (st_valid) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= st_data[63:0];
                        out_last  <= (rem == REM_ONE);
                        fsm       <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_hs) begin
                        rem <= rem - REM_ONE;
                        if (rem == REM_ONE) begin
                            idx       <= idx_inc;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            fsm       <= S_IDLE;
                        end else if (idx == LAST_IDX) begin
                            idx       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            perm_req  <= 1'b1;
                            fsm       <= S_WAIT_ST;
                        end else begin
                            idx       <= idx_inc;
                            out_data  <= next_lane;
                            out_last  <= (rem == REM_TWO);
                        end
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

endmodule
